// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
//   Multi-cycle adder/subtractor. Adds (sub=0: a+b+ci) or subtracts
//   (sub=1: a+~b+1) two WIDTH-bit operands CHUNK bits per clock, keeping the
//   inter-chunk carry in a register. Operands are taken on an in_valid/in_ready
//   handshake and the result is offered on an out_valid/out_ready handshake.
//   Latency from the accept edge to out_valid is NCH = WIDTH/CHUNK cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   a, b, ci, sub   operands, carry-in (add only), subtract select
//   in_valid        operands valid
//   in_ready        block idle and able to accept (decoded from state)
//   S, cout, ovf    result, MSB carry-out, two's-complement overflow
//   out_valid       result valid, held until out_ready
//   out_ready       consumer takes the result
module chunk_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic             carry_q, cout_q, ovf_q, out_valid_q;
   logic [KW-1:0]    k_q;

   // Current chunk arithmetic
   logic [CHUNK-1:0] ach_d, bch_d;
   logic [CHUNK:0]   sum_d;
   logic             cmsb_d;

   always_comb begin
      ach_d  = a_q[k_q*CHUNK +: CHUNK];
      bch_d  = b_q[k_q*CHUNK +: CHUNK];
      sum_d  = {1'b0, ach_d} + {1'b0, bch_d} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the chunk's top bit recovered from its sum bit:
      // sum = a ^ b ^ cin  =>  cin = a ^ b ^ sum.
      cmsb_d = ach_d[CHUNK-1] ^ bch_d[CHUNK-1] ^ sum_d[CHUNK-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         k_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub | ci;
                  s_q     <= '0;
                  k_q     <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               s_q[k_q*CHUNK +: CHUNK] <= sum_d[CHUNK-1:0];
               carry_q <= sum_d[CHUNK];
               k_q     <= k_q + KW'(1);
               if (k_q == KLAST) begin
                  cout_q      <= sum_d[CHUNK];
                  ovf_q       <= cmsb_d ^ sum_d[CHUNK];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign S         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: directed table on the default (16,4) build,
// hand-written backpressure and mid-RUN reset sequences, and a random sweep
// over (8,1), (16,16) and (32,8) builds driven in parallel.
module tb_chunk_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic        ci, sub, ordy;
   logic [3:0]  iv;

   always #5 clk = ~clk;

   logic        ir0, co0, ov0, vo0;
   logic [15:0] s0;
   logic        ir1, co1, ov1, vo1;
   logic [7:0]  s1;
   logic        ir2, co2, ov2, vo2;
   logic [15:0] s2;
   logic        ir3, co3, ov3, vo3;
   logic [31:0] s3;

   chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u0 (
      .clk(clk), .rst(rst), .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub),
      .in_valid(iv[0]), .in_ready(ir0), .S(s0), .cout(co0), .ovf(ov0),
      .out_valid(vo0), .out_ready(ordy));
   chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
      .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub),
      .in_valid(iv[1]), .in_ready(ir1), .S(s1), .cout(co1), .ovf(ov1),
      .out_valid(vo1), .out_ready(ordy));
   chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u2 (
      .clk(clk), .rst(rst), .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub),
      .in_valid(iv[2]), .in_ready(ir2), .S(s2), .cout(co2), .ovf(ov2),
      .out_valid(vo2), .out_ready(ordy));
   chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u3 (
      .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .sub(sub),
      .in_valid(iv[3]), .in_ready(ir3), .S(s3), .cout(co3), .ovf(ov3),
      .out_valid(vo3), .out_ready(ordy));

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid on the default instance; lat = edges waited, -1 on timeout
   task automatic wait_out(output int lat);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (vo0) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) chk("timeout_out_valid", 64'd0, 64'd1);
   endtask

   // Independent reference: W-bit add/sub with sign-rule overflow
   task automatic model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                        input logic cii, input logic subi,
                        output logic [63:0] s, output logic c, output logic o);
      logic [63:0] mask, aa, bb, full;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'd0, ai} & mask;
      bb   = (subi ? ~{32'd0, bi} : {32'd0, bi}) & mask;
      full = aa + bb + {63'd0, (subi | cii)};
      s    = full & mask;
      c    = full[w];
      o    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic        ci, sub;
      logic [15:0] s;
      logic        cout, ovf;
   } vec_t;

   vec_t vt[9];
   int   lat;
   logic [15:0] hold_s;

   initial begin
      vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
      vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0; ordy = 1'b1; iv = '0;
      tick();
      tick();
      chk("rst_S", {48'd0, s0}, 64'd0);
      chk("rst_cout", {63'd0, co0}, 64'd0);
      chk("rst_ovf", {63'd0, ov0}, 64'd0);
      chk("rst_out_valid", {63'd0, vo0}, 64'd0);
      chk("rst_in_ready_low", {63'd0, ir0}, 64'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", {63'd0, ir0}, 64'd1);

      // Directed table on the default build
      foreach (vt[i]) begin
         a = {16'd0, vt[i].a}; b = {16'd0, vt[i].b}; ci = vt[i].ci; sub = vt[i].sub;
         iv[0] = 1'b1;
         tick();
         iv[0] = 1'b0;
         a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; ci = ~ci; sub = ~sub;
         chk($sformatf("v%0d_in_ready_run", i), {63'd0, ir0}, 64'd0);
         wait_out(lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("v%0d_S", i), {48'd0, s0}, {48'd0, vt[i].s});
         chk($sformatf("v%0d_cout", i), {63'd0, co0}, {63'd0, vt[i].cout});
         chk($sformatf("v%0d_ovf", i), {63'd0, ov0}, {63'd0, vt[i].ovf});
         tick();
         chk($sformatf("v%0d_out_valid_drop", i), {63'd0, vo0}, 64'd0);
         chk($sformatf("v%0d_in_ready_back", i), {63'd0, ir0}, 64'd1);
      end

      // Backpressure: result held in DONE while a new op waits on in_valid
      ordy = 1'b0;
      a = 32'h1111; b = 32'h2222; ci = 1'b0; sub = 1'b0; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      wait_out(lat);
      chk("bp_S_first", {48'd0, s0}, 64'h3333);
      a = 32'h0F0F; b = 32'h0101; ci = 1'b0; sub = 1'b0; iv[0] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk($sformatf("bp_hold_valid_%0d", n), {63'd0, vo0}, 64'd1);
         chk($sformatf("bp_hold_S_%0d", n), {48'd0, s0}, 64'h3333);
         chk($sformatf("bp_hold_cout_ovf_%0d", n), {62'd0, co0, ov0}, 64'd0);
         chk($sformatf("bp_in_ready_%0d", n), {63'd0, ir0}, 64'd0);
      end
      ordy = 1'b1;
      tick();
      chk("bp_handshake_drop", {63'd0, vo0}, 64'd0);
      chk("bp_in_ready_idle", {63'd0, ir0}, 64'd1);
      tick();
      iv[0] = 1'b0;
      chk("bp_second_accepted", {63'd0, ir0}, 64'd0);
      wait_out(lat);
      chk("bp_second_latency", 64'(lat), 64'd4);
      chk("bp_second_S", {48'd0, s0}, 64'h1010);
      tick();

      // Reset in the second RUN cycle of an op that generates a carry
      a = 32'hFFFF; b = 32'h0001; ci = 1'b0; sub = 1'b0; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_out_valid", {63'd0, vo0}, 64'd0);
      chk("mid_rst_S", {48'd0, s0}, 64'd0);
      chk("mid_rst_cout_ovf", {62'd0, co0, ov0}, 64'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", {63'd0, ir0}, 64'd1);
      a = 32'h0; b = 32'h0; ci = 1'b0; sub = 1'b0; iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      wait_out(lat);
      chk("post_rst_latency", 64'(lat), 64'd4);
      chk("post_rst_S", {48'd0, s0}, 64'd0);
      chk("post_rst_cout", {63'd0, co0}, 64'd0);
      tick();

      // Parameter sweep: the three alternate builds run the same operands
      for (int it = 0; it < 6; it++) begin
         logic [63:0] es;
         logic        ec, eo;
         int          l1, l2, l3;
         logic [63:0] r1, r2, r3;
         a = $urandom(); b = $urandom(); ci = 1'($urandom_range(0, 1));
         sub = (it % 2 == 1);
         if (it == 0) begin a = 32'hFFFF_FFFF; b = 32'h1; ci = 1'b0; end
         iv[3:1] = 3'b111;
         tick();
         iv[3:1] = 3'b000;
         l1 = -1; l2 = -1; l3 = -1; r1 = '0; r2 = '0; r3 = '0;
         for (int n = 1; n <= 12; n++) begin
            tick();
            if (vo1 && l1 < 0) begin l1 = n; r1 = {54'd0, s1, co1, ov1}; end
            if (vo2 && l2 < 0) begin l2 = n; r2 = {46'd0, s2, co2, ov2}; end
            if (vo3 && l3 < 0) begin l3 = n; r3 = {30'd0, s3, co3, ov3}; end
         end
         model(8, a, b, ci, sub, es, ec, eo);
         chk($sformatf("sw%0d_8_1_lat", it), 64'(l1), 64'd8);
         chk($sformatf("sw%0d_8_1_res", it), r1, {es[61:0], ec, eo});
         model(16, a, b, ci, sub, es, ec, eo);
         chk($sformatf("sw%0d_16_16_lat", it), 64'(l2), 64'd1);
         chk($sformatf("sw%0d_16_16_res", it), r2, {es[61:0], ec, eo});
         model(32, a, b, ci, sub, es, ec, eo);
         chk($sformatf("sw%0d_32_8_lat", it), 64'(l3), 64'd4);
         chk($sformatf("sw%0d_32_8_res", it), r3, {es[61:0], ec, eo});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Parametrised multi-cycle adder/subtractor, the next generation of the team's 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks. It uses a valid/ready handshake on both sides, so a wide add costs a narrow adder plus registers instead of a WIDTH-bit ripple chain. It sits between operand producers and any consumer that can tolerate WIDTH/CHUNK cycles of latency.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCH = WIDTH/CHUNK.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+ci; 1: a-b, computed as a+~b+1, with ci ignored.
- in_valid  input  1  operands are valid.
- in_ready  output  1  block accepts operands.
- S  output  WIDTH  result.
- cout  output  1  carry out of the MSB; in sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  S, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture a, b (inverted when sub=1) and carry (ci, or 1 when sub=1) into registers. Clear S and the chunk index, then go to RUN.
  - RUN: each cycle, add chunk k of A, B and the carry register, write the result into S[k*CHUNK +: CHUNK], update carry, and k++. When k = NCH-1, latch cout and ovf and go to DONE.
  - DONE: out_valid=1. S, cout and ovf are held stable. On out_ready, go to IDLE.
- in_ready = (state==IDLE) & ~rst. in_ready is 0 in RUN and DONE, so in_valid is ignored there.
- Inputs a, b, ci and sub are sampled only at the accept edge. Changes during RUN or DONE have no effect.
- ovf = carry into bit WIDTH-1 XOR cout, taken from the final chunk.
- NCH=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.
- out_ready while out_valid=0 has no effect.
- Reset on any clk edge with rst=1 forces:
  - state = IDLE,
  - S = 0, cout = 0, ovf = 0, out_valid = 0,
  - internal carry and chunk index = 0.
- Reset takes priority over every other event, including mid-RUN and in DONE with out_ready=1. Any in-flight operation is discarded.

## Timing
- Accept edge E0. Chunk k is written at edge E(k+1). out_valid rises after edge E_NCH, i.e. latency is NCH cycles: 4 for the defaults.
- The output handshake completes at the first edge with out_valid & out_ready. out_valid drops after that edge, and in_ready is 1 from the next cycle.
- The next accept is at the earliest one cycle after the output handshake. Minimum period per operation is NCH+2 cycles.
- All outputs are registered except in_ready, which decodes the state register.
- in_ready is 1 in the first cycle after rst deasserts.

## Test plan
Defaults are WIDTH=16, CHUNK=4.
- Basic add: a=0x1234, b=0x4321, ci=0, sub=0 → S=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF, b=0x0001, ci=0 → S=0x0000, cout=1, ovf=0. Also a=0x00FF, b=0x0000, ci=1 → S=0x0100, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001 → S=0x8000, cout=0, ovf=1. Subtract: a=0x0005, b=0x0007, sub=1, ci=1 → S=0xFFFE, cout=0, ovf=0 (ci ignored).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands. Required: S, cout and ovf stable; in_ready=0; no second accept. After out_ready=1, the second operation is accepted one cycle later and produces its correct result.
- Reset mid-operation: assert rst for one cycle in the second RUN cycle. Required, after that edge: out_valid=0, S=0, cout=0, ovf=0, in_ready=1. A subsequent op completes with the correct result and no leftover carry.
- Parameter sweep: random operands at (WIDTH,CHUNK) = (8,1), (16,16), (32,8), checked against a+b+ci and a-b. Latency must equal WIDTH/CHUNK in each case.
